// File: rtl/seq_mult.sv
// -----------------------------------------------------------------------------
// seq_mult -- sequential shift-add unsigned multiplier
//
// Computes P = A * B (both W-bit unsigned, 2W-bit product) with one shift-add
// step per clock. A three-state FSM (IDLE, RUN, DONE) sequences the operation.
// A single W-bit adder with carry-out forms each partial sum, so the datapath
// never needs a 2W-bit adder.
//
// Optional feature (compile-time macro):
//   EARLY_TERM_EN - when every multiplier bit still waiting in Q is zero, the
//                   remaining shifts are applied in one cycle and the block
//                   finishes early. When it is undefined, latency is a fixed
//                   W+1 cycles and no early-termination logic exists.
//
// Parameters:
//   W      operand width in bits (8..64); the product is 2*W bits wide
//
// Ports:
//   clk    in   rising-edge clock for all state
//   rst_n  in   asynchronous active-low reset
//   start  in   start request; accepted in IDLE or DONE, ignored in RUN
//   A      in   W-bit multiplicand, sampled only when start is accepted
//   B      in   W-bit multiplier, sampled only when start is accepted
//   busy   out  high exactly while in RUN
//   done   out  one-cycle pulse, high exactly while in DONE
//   P      out  2W-bit registered product, valid from the done cycle until
//               the next accepted start (and held beyond it)
// -----------------------------------------------------------------------------
module seq_mult #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] P
);

  // Counter holds 0..W, so it needs ceil(log2(W+1)) bits.
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [W-1:0]    r_m;      // latched multiplicand
  logic [W-1:0]    r_acc;    // upper half of the running product
  logic [W-1:0]    r_q;      // lower half; low bits are unconsumed multiplier bits
  logic [CW-1:0]   r_count;  // number of shift-add steps already performed
  logic [2*W-1:0]  r_p;

  logic            w_accept;   // start taken this cycle (IDLE or DONE)
  logic            w_last;     // this RUN cycle performs the W-th step
  logic            w_finish;   // this RUN cycle is the final one
  logic [W-1:0]    w_addend;
  logic [W-1:0]    w_sum;
  logic            w_carry;
  logic [2*W-1:0]  w_step_val; // {ACC,Q} after one ordinary shift-add step
  logic [2*W-1:0]  w_result;   // {ACC,Q} value to load this RUN cycle

  // ---------------------------------------------------------------------------
  // Shift-add datapath
  // ---------------------------------------------------------------------------
  assign w_addend = r_q[0] ? r_m : '0;

  // W-bit add; the extra MSB on each side only exposes the carry-out.
  assign {w_carry, w_sum} = {1'b0, r_acc} + {1'b0, w_addend};

  // {C, sum, Q} shifted right by one and truncated to 2W bits: Q[0] has been
  // consumed and drops off the bottom, the carry becomes the new ACC MSB.
  assign w_step_val = {w_carry, w_sum, r_q[W-1:1]};

  assign w_last = (r_count == CW'(W - 1));

`ifdef EARLY_TERM_EN
  logic [W-1:0]  w_pending_mask; // marks the multiplier bits not yet consumed
  logic [CW-1:0] w_remaining;    // shifts still owed: W - count
  logic          w_early;
  logic [2*W-1:0] w_aligned;

  // After count steps the unconsumed multiplier bits sit in Q[W-1-count:0].
  // If they are all zero, every remaining step would add nothing and just
  // shift, so the whole remainder collapses into one right shift.
  assign w_pending_mask = {W{1'b1}} >> r_count;
  assign w_early        = ((r_q & w_pending_mask) == '0);
  assign w_remaining    = CW'(W) - r_count;
  assign w_aligned      = {r_acc, r_q} >> w_remaining;

  assign w_result = w_early ? w_aligned : w_step_val;
  assign w_finish = w_early | w_last;
`else
  assign w_result = w_step_val;
  assign w_finish = w_last;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state and control
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        // start is deliberately not looked at here.
        if (w_finish) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        // Back-to-back: a start seen in DONE goes straight to RUN.
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand, accumulator, counter and product registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m     <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_count <= '0;
      r_p     <= '0;
    end else if (w_accept) begin
      r_m     <= A;
      r_q     <= B;
      r_acc   <= '0;
      r_count <= '0;
    end else if (r_state == S_RUN) begin
      {r_acc, r_q} <= w_result;
      r_count      <= r_count + CW'(1);
      // P only moves on the edge that enters DONE, so it holds the previous
      // result through IDLE and through the RUN phase of the next operation.
      if (w_finish) begin
        r_p <= w_result;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Decoded straight from the state register, so reset clears them at once
  // and busy/done can never be high together.
  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign P    = r_p;

endmodule

// File: tb/tb_seq_mult.sv
// -----------------------------------------------------------------------------
// tb_seq_mult -- self-checking bench for seq_mult (W = 32)
//
// Expected products come from plain 2W-bit multiplication and expected
// latencies from the operand value (fixed W, or derived from the position of
// the highest set bit of B when EARLY_TERM_EN is defined). Outputs are
// sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_seq_mult;

  localparam int W = 32;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a     = '0;
  logic [W-1:0]   b     = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] p;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_mult #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (a),
    .B     (b),
    .busy  (busy),
    .done  (done),
    .P     (p)
  );

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Rising edges from the accept edge until the edge that enters DONE.
  function automatic int exp_latency(input logic [W-1:0] bv);
`ifdef EARLY_TERM_EN
    int msb;
    msb = -1;
    for (int i = 0; i < W; i++) if (bv[i]) msb = i;
    if (msb < 0) return 1;
    // Bits 0..msb each need a real step; one more cycle aligns the rest.
    return (msb + 2 > W) ? W : msb + 2;
`else
    return W + (bv == bv ? 0 : 1);
`endif
  endfunction

  function automatic logic [2*W-1:0] ref_product(input logic [W-1:0] av,
                                                  input logic [W-1:0] bv);
    logic [2*W-1:0] xa, xb;
    xa = {{W{1'b0}}, av};
    xb = {{W{1'b0}}, bv};
    return xa * xb;
  endfunction

  // Called with start/A/B already driven ahead of the accept edge.
  task automatic finish_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                           input bit noisy);
    logic [2*W-1:0] exp_p;
    int l_exp;
    int lat;
    exp_p = ref_product(av, bv);
    l_exp = exp_latency(bv);
    lat   = W + 6;
    @(posedge clk); #1;
    check("busy_after_accept", busy, 1);
    start = noisy ? ($urandom_range(0, 3) == 0) : 1'b0;
    a = $urandom;
    b = $urandom;
    for (int cyc = 1; cyc <= W + 5; cyc++) begin
      @(posedge clk); #1;
      check("busy_done_overlap", busy & done, 0);
      if (done) begin
        lat = cyc;
        break;
      end
      check("busy_in_run", busy, 1);
      // Extra start pulses only on edges where the DUT is still in RUN.
      start = noisy && (cyc < l_exp) && ($urandom_range(0, 3) == 0);
      a = $urandom;
      b = $urandom;
    end
    start = 1'b0;
    check("latency", lat, l_exp);
    check("product", p, exp_p);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("idle_not_busy", busy, 0);
    check("product_hold", p, exp_p);
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input bit noisy);
    @(negedge clk);
    start = 1'b1;
    a = av;
    b = bv;
    finish_op(av, bv, noisy);
  endtask

  // start held high across two operations; operands change at DONE.
  task automatic back_to_back();
    int c1, c2;
    c1 = W + 6;
    c2 = W + 6;
    @(negedge clk);
    start = 1'b1;
    a = 7;
    b = 9;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= W + 5; cyc++) begin
      a = $urandom;
      b = $urandom;
      @(posedge clk); #1;
      if (done) begin
        c1 = cyc;
        break;
      end
    end
    check("b2b_first_latency", c1, exp_latency(9));
    check("b2b_first_product", p, 63);
    a = 2;
    b = 4;
    for (int cyc = 1; cyc <= W + 6; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) begin
        check("b2b_rerun_busy", busy, 1);
        check("b2b_p_held_in_run", p, 63);
      end
      a = $urandom;
      b = $urandom;
      if (done) begin
        c2 = cyc;
        break;
      end
    end
    start = 1'b0;
    check("b2b_done_spacing", c2, exp_latency(4) + 1);
    check("b2b_second_product", p, 8);
    @(posedge clk); #1;
    check("b2b_back_to_idle", busy | done, 0);
  endtask

  task automatic reset_abort();
    bit saw_done;
    run_op(5, 7, 1'b0);
    @(negedge clk);
    start = 1'b1;
    a = 100;
    b = 200;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_p", p, 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    check("no_activity_after_abort", saw_done, 0);
    // start present on the very first edge after reset release.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    a = 100;
    b = 200;
    finish_op(100, 200, 1'b0);
    check("post_reset_product", p, 20000);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state_busy", busy, 0);
    check("reset_state_done", done, 0);
    check("reset_state_p", p, 0);

    // Release reset with start already asserted.
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    a = 3;
    b = 5;
    finish_op(3, 5, 1'b0);
    check("p_3x5", p, 15);

    run_op('1, '1, 1'b0);
    check("p_max_max", p, 64'hFFFFFFFE00000001);
    run_op(0, 32'h12345678, 1'b0);
    run_op(32'h12345678, 0, 1'b0);
    run_op(32'hDEADBEEF, 1, 1'b0);
    check("p_deadbeef_x1", p, 64'h00000000DEADBEEF);
    run_op(32'hDEADBEEF, 32'h80000000, 1'b0);
    run_op(32'h0000FFFF, 32'h00010000, 1'b1);

    back_to_back();
    reset_abort();

    for (int n = 0; n < 1200; n++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = rb >> $urandom_range(0, W - 1);
        1: rb = '0;
        2: ra = '1;
        3: rb = '1;
        default: ;
      endcase
      run_op(ra, rb, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_mult.md
SEQ_MULT -- requirements
Module: seq_mult

Interface
REQ-001 Parameter W, default 32, operand width in bits; product width is 2*W; legal values 8..64.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request to begin a multiplication; sampled on rising clk.
REQ-005 A  input  W  multiplicand, unsigned; sampled only when start is accepted.
REQ-006 B  input  W  multiplier, unsigned; sampled only when start is accepted.
REQ-007 busy  output  1  high while an operation is in progress (state RUN).
REQ-008 done  output  1  single-cycle pulse; high for exactly one cycle when P becomes valid.
REQ-009 P  output  2*W  product A*B, registered; valid from the done cycle until the next accepted start.

Function
REQ-010 The block SHALL have a three-state FSM (IDLE, RUN, DONE) and an iteration counter of ceil(log2(W+1)) bits.
REQ-011 start SHALL be accepted in IDLE or DONE: latch M<=A, Q<=B, ACC<=0, count<=0, go to RUN; start in RUN SHALL be ignored, with no effect on operands or timing.
REQ-012 Each RUN cycle SHALL perform one shift-add step: sum = ACC + (Q[0] ? M : 0) as W-bit add with carry-out C; then {ACC,Q} <= {C, sum, Q} >> 1 (a 2W+1-bit right shift truncated to 2W bits); count <= count+1.
REQ-013 The add in REQ-012 SHALL be a W-bit unsigned adder producing a W-bit sum and a carry-out; no wider adder SHALL be used.
REQ-014 After the W-th step, the FSM SHALL go to DONE; P <= {ACC,Q} final value on that same edge.
REQ-015 Latency: start accepted at edge k; done high in the cycle after edge k+W (W+1 cycles start-to-done without EARLY_TERM_EN).
REQ-016 DONE SHALL last one cycle, then go to IDLE unless start is high, in which case it goes directly to RUN (back-to-back).
REQ-017 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE; busy and done SHALL never both be 1.
REQ-018 P SHALL change only on the edge that enters DONE; it SHALL hold its value through IDLE and through RUN of a subsequent operation.
REQ-019 A and B changes after acceptance SHALL not affect the result.
REQ-020 Result SHALL be exact for all operands, including A=2^W-1, B=2^W-1 (no overflow; 2W-bit product).

Reset
REQ-021 rst_n low SHALL immediately (asynchronously) force state=IDLE, busy=0, done=0, P=0, ACC=0, Q=0, M=0, count=0.
REQ-022 Reset asserted mid-operation SHALL abort it; no done pulse SHALL follow deassertion.
REQ-023 start SHALL be honoured on the first rising edge after rst_n deasserts.

Configuration
REQ-024 Macro EARLY_TERM_EN: when defined, at each RUN cycle, if all not-yet-consumed multiplier bits of Q are 0, the block SHALL instead align {ACC,Q} by the remaining (W-count) shift positions in one cycle, load P with it, and enter DONE.
REQ-025 With EARLY_TERM_EN, B=0 SHALL give done in the cycle after edge k+1; B=1 SHALL give done after edge k+2; results SHALL match REQ-020 in all cases.
REQ-026 Without EARLY_TERM_EN, latency SHALL be the fixed W+1 cycles for every operand value, and no early-termination logic SHALL be present.

Verification
REQ-027 W=32, A=3, B=5, start one cycle -> busy high 32 cycles, done pulse 33 cycles after start edge, P=15.
REQ-028 A=32'hFFFFFFFF, B=32'hFFFFFFFF -> P=64'hFFFFFFFE00000001; A=0, B=32'h12345678 -> P=0.
REQ-029 start held high continuously with A=7, B=9 then A=2, B=4 changed at DONE -> done pulses every 33 cycles, P=63 then P=8; start pulses during RUN ignored.
REQ-030 rst_n pulled low at iteration 10 of A=100, B=200 -> busy=0, done=0, P=0 immediately; no done pulse afterwards; new start gives P=20000.
REQ-031 EARLY_TERM_EN defined: B=0 -> done 2 cycles after start edge, P=0; B=1, A=32'hDEADBEEF -> done 3 cycles after start edge, P=64'h00000000DEADBEEF; B=32'h80000000 -> full latency, P=A<<31.
REQ-032 Random 10k operand pairs, both macro settings -> P equals 64-bit reference product every time; busy/done never overlap.
